// File: rtl/moving_average_pkg.sv
// -----------------------------------------------------------------------------
// moving_average_pkg
// Shared helpers for the moving_average_n block:
//   sum_width()    - accumulator width that cannot wrap for 2**log2n samples
//   round_offset() - half-LSB offset added before the divide-by-N shift
//   params_legal() - parameter legality (data_w >= 2, 1 <= log2n <= 8)
// -----------------------------------------------------------------------------
package moving_average_pkg;

  function automatic int sum_width(input int data_w, input int log2n);
    return data_w + log2n;
  endfunction

  function automatic int round_offset(input int log2n);
    return (log2n > 0) ? (1 << (log2n - 1)) : 0;
  endfunction

  function automatic bit params_legal(input int data_w, input int log2n);
    return (data_w >= 2) && (log2n >= 1) && (log2n <= 8);
  endfunction

endpackage

// File: rtl/mavg_window_buf.sv
// -----------------------------------------------------------------------------
// mavg_window_buf
// Circular sample window of N = 2**LOG2N entries with write pointer and a
// saturating fill counter. Presents the sample about to be evicted.
// Ports:
//   clk       - clock
//   rst_n     - asynchronous reset, active low (pointer/fill/full only)
//   i_clr     - synchronous clear of pointer and fill; blocks the write
//   i_accept  - write i_data this cycle
//   i_data    - sample to store
//   o_oldest  - entry at the write pointer once the window is full, else 0
//   o_full    - registered, high while the window holds N samples
// -----------------------------------------------------------------------------
module mavg_window_buf
  import moving_average_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LOG2N  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_accept,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_oldest,
  output logic              o_full
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N:0]   FILL_MAX = (LOG2N+1)'(N);
  localparam logic [LOG2N:0]   FILL_NM1 = (LOG2N+1)'(N - 1);
  localparam logic [LOG2N:0]   FILL_ONE = (LOG2N+1)'(1);
  localparam logic [LOG2N-1:0] PTR_ONE  = LOG2N'(1);

  logic [DATA_W-1:0] r_mem [N];
  logic [LOG2N-1:0]  r_wr_ptr;
  logic [LOG2N:0]    r_fill;
  logic              r_full;
  logic              w_write;

  assign w_write = i_accept && !i_clr;

  // Storage is deliberately not reset: the full flag masks stale contents.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_full   <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
      r_full   <= 1'b0;
    end else if (i_accept) begin
      // Pointer is exactly LOG2N bits, so N-1 -> 0 wraps naturally.
      r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (r_fill != FILL_MAX) begin
        r_fill <= r_fill + FILL_ONE;
      end
      // Full after this write if we were at N-1 or already full.
      r_full <= (r_fill >= FILL_NM1);
    end
  end

  // Once full, the write pointer addresses the oldest sample.
  assign o_oldest = r_full ? r_mem[r_wr_ptr] : '0;
  assign o_full   = r_full;

endmodule

// File: rtl/moving_average_n.sv
// -----------------------------------------------------------------------------
// moving_average_n
// Running sum and mean over the last N = 2**LOG2N accepted signed samples.
// The accumulator is DATA_W+LOG2N bits wide so it can never wrap. Results are
// registered one cycle after each accepted sample. During warm-up the mean is
// sum/N with zero padding.
// Optional build macro: MOVING_AVERAGE_ROUND_EN - when defined, out_avg rounds
// half toward +inf instead of flooring; out_sum is unaffected.
// Ports:
//   system1000       - clock
//   system1000_rstn  - asynchronous reset, active low
//   clr              - synchronous clear of window state, overrides in_valid
//   in_valid         - in_data carries a sample this cycle
//   in_data          - signed sample, DATA_W bits
//   out_valid        - out_avg/out_sum updated this cycle
//   out_avg          - signed window mean, DATA_W bits
//   out_sum          - signed window sum, SUM_W bits
//   out_full         - window holds N valid samples
// -----------------------------------------------------------------------------
module moving_average_n
  import moving_average_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int LOG2N  = 4,
  localparam int SUM_W  = sum_width(DATA_W, LOG2N)
) (
  input  logic                     system1000,
  input  logic                     system1000_rstn,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_avg,
  output logic signed [SUM_W-1:0]  out_sum,
  output logic                     out_full
);

  if (!params_legal(DATA_W, LOG2N)) begin : g_bad_params
    $error("moving_average_n: need DATA_W >= 2 and 1 <= LOG2N <= 8");
  end

  logic [DATA_W-1:0]        w_oldest;
  logic                     w_full;
  logic signed [SUM_W-1:0]  w_in_ext;
  logic signed [SUM_W-1:0]  w_old_ext;
  logic signed [SUM_W-1:0]  w_sum_n;
  logic signed [DATA_W-1:0] w_avg;

  logic                     r_valid;
  logic signed [SUM_W-1:0]  r_sum;
  logic signed [DATA_W-1:0] r_avg;

  mavg_window_buf #(
    .DATA_W (DATA_W),
    .LOG2N  (LOG2N)
  ) u_win (
    .clk      (system1000),
    .rst_n    (system1000_rstn),
    .i_clr    (clr),
    .i_accept (in_valid),
    .i_data   (in_data),
    .o_oldest (w_oldest),
    .o_full   (w_full)
  );

  assign w_in_ext  = {{LOG2N{in_data[DATA_W-1]}}, in_data};
  assign w_old_ext = {{LOG2N{w_oldest[DATA_W-1]}}, w_oldest};
  assign w_sum_n   = r_sum + w_in_ext - w_old_ext;

`ifdef MOVING_AVERAGE_ROUND_EN
  localparam logic signed [SUM_W:0] RND_OFF = (SUM_W+1)'(round_offset(LOG2N));

  logic signed [SUM_W:0] w_rnd;
  logic                  w_unused_rnd;

  // One guard bit keeps the offset add from wrapping; the shifted and
  // truncated result always fits DATA_W.
  assign w_rnd        = {w_sum_n[SUM_W-1], w_sum_n} + RND_OFF;
  assign w_avg        = w_rnd[LOG2N +: DATA_W];
  assign w_unused_rnd = ^{w_rnd[SUM_W], w_rnd[LOG2N-1:0]};
`else
  // Arithmetic shift right by LOG2N then truncate to DATA_W is exactly the
  // upper DATA_W bits of the sum (floor toward -inf).
  assign w_avg = w_sum_n[SUM_W-1:LOG2N];
`endif

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_avg   <= '0;
    end else if (clr) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_avg   <= '0;
    end else if (in_valid) begin
      r_valid <= 1'b1;
      r_sum   <= w_sum_n;
      r_avg   <= w_avg;
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_sum   = r_sum;
  assign out_avg   = r_avg;
  assign out_full  = w_full;

endmodule

// File: tb/tb_moving_average_n.sv
module tb_moving_average_n;

  localparam int DATA_W = 8;
  localparam int LOG2N  = 2;
  localparam int SUM_W  = DATA_W + LOG2N;

  logic                     system1000;
  logic                     system1000_rstn;
  logic                     clr;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_avg;
  logic signed [SUM_W-1:0]  out_sum;
  logic                     out_full;

  int n_total = 0;
  int n_pass  = 0;

  moving_average_n #(
    .DATA_W (DATA_W),
    .LOG2N  (LOG2N)
  ) dut (
    .system1000      (system1000),
    .system1000_rstn (system1000_rstn),
    .clr             (clr),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_avg         (out_avg),
    .out_sum         (out_sum),
    .out_full        (out_full)
  );

  initial system1000 = 1'b0;
  always #5 system1000 = ~system1000;

  // Apply inputs on the falling edge, return 1 time unit after the rising edge.
  task automatic drive(input logic v, input int d, input logic c);
    @(negedge system1000);
    in_valid = v;
    in_data  = DATA_W'(d);
    clr      = c;
    @(posedge system1000);
    #1;
  endtask

  task automatic test_reset();
    system1000_rstn = 1'b0;
    clr = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge system1000);
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", out_valid); else n_pass++;
    n_total++; if (out_sum !== '0) $display("FAIL reset_sum: got %0d expected 0", out_sum); else n_pass++;
    n_total++; if (out_avg !== '0) $display("FAIL reset_avg: got %0d expected 0", out_avg); else n_pass++;
    n_total++; if (out_full !== 1'b0) $display("FAIL reset_full: got %0b expected 0", out_full); else n_pass++;
    @(negedge system1000);
    system1000_rstn = 1'b1;
  endtask

  task automatic test_warmup(input string tag);
    int din [4] = '{4, 8, 12, 16};
    int es  [4] = '{4, 12, 24, 40};
    int ea  [4] = '{1, 3, 6, 10};
    logic ef [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, din[i], 1'b0);
      n_total++; if (out_valid !== 1'b1) $display("FAIL %s_valid[%0d]: got %0b expected 1", tag, i, out_valid); else n_pass++;
      n_total++; if (out_sum !== SUM_W'(es[i])) $display("FAIL %s_sum[%0d]: got %0d expected %0d", tag, i, out_sum, es[i]); else n_pass++;
      n_total++; if (out_avg !== DATA_W'(ea[i])) $display("FAIL %s_avg[%0d]: got %0d expected %0d", tag, i, out_avg, ea[i]); else n_pass++;
      n_total++; if (out_full !== ef[i]) $display("FAIL %s_full[%0d]: got %0b expected %0b", tag, i, out_full, ef[i]); else n_pass++;
    end
  endtask

  task automatic test_evict();
    drive(1'b1, 20, 1'b0);
    n_total++; if (out_sum !== SUM_W'(56)) $display("FAIL evict_sum: got %0d expected 56", out_sum); else n_pass++;
    n_total++; if (out_avg !== DATA_W'(14)) $display("FAIL evict_avg: got %0d expected 14", out_avg); else n_pass++;
    drive(1'b0, 99, 1'b0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL idle_valid: got %0b expected 0", out_valid); else n_pass++;
    n_total++; if (out_sum !== SUM_W'(56)) $display("FAIL idle_sum_hold: got %0d expected 56", out_sum); else n_pass++;
    n_total++; if (out_avg !== DATA_W'(14)) $display("FAIL idle_avg_hold: got %0d expected 14", out_avg); else n_pass++;
  endtask

  task automatic test_extremes();
    // Window entering: 8,12,16,20
    int es_hi [6] = '{175, 290, 401, 508, 508, 508};
    int es_lo [4] = '{253, -2, -257, -512};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 127, 1'b0);
      n_total++; if (out_sum !== SUM_W'(es_hi[i])) $display("FAIL max_sum[%0d]: got %0d expected %0d", i, out_sum, es_hi[i]); else n_pass++;
    end
    n_total++; if (out_avg !== DATA_W'(127)) $display("FAIL max_avg: got %0d expected 127", out_avg); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, -128, 1'b0);
      n_total++; if (out_sum !== SUM_W'(es_lo[i])) $display("FAIL min_sum[%0d]: got %0d expected %0d", i, out_sum, es_lo[i]); else n_pass++;
    end
    n_total++; if (out_avg !== DATA_W'(-128)) $display("FAIL min_avg: got %0d expected -128", out_avg); else n_pass++;
    n_total++; if (out_full !== 1'b1) $display("FAIL min_full: got %0b expected 1", out_full); else n_pass++;
  endtask

  task automatic test_rounding();
    int first [3] = '{1, 2, -1};
`ifdef MOVING_AVERAGE_ROUND_EN
    int eavg  [3] = '{0, 1, 0};
`else
    int eavg  [3] = '{0, 0, -1};
`endif
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 0, 1'b1);
      n_total++; if (out_full !== 1'b0) $display("FAIL rnd_clr_full[%0d]: got %0b expected 0", k, out_full); else n_pass++;
      drive(1'b1, first[k], 1'b0);
      for (int j = 0; j < 3; j++) drive(1'b1, 0, 1'b0);
      n_total++; if (out_sum !== SUM_W'(first[k])) $display("FAIL rnd_sum[%0d]: got %0d expected %0d", k, out_sum, first[k]); else n_pass++;
      n_total++; if (out_avg !== DATA_W'(eavg[k])) $display("FAIL rnd_avg[%0d]: got %0d expected %0d", k, out_avg, eavg[k]); else n_pass++;
    end
  endtask

  task automatic test_gapped();
`ifdef MOVING_AVERAGE_ROUND_EN
    int e30 = 8;
`else
    int e30 = 7;
`endif
    drive(1'b0, 0, 1'b1);
    drive(1'b1, 10, 1'b0);
    n_total++; if (out_sum !== SUM_W'(10)) $display("FAIL gap_sum0: got %0d expected 10", out_sum); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 77, 1'b0);
      n_total++; if (out_valid !== 1'b0) $display("FAIL gap_valid[%0d]: got %0b expected 0", i, out_valid); else n_pass++;
      n_total++; if (out_sum !== SUM_W'(10)) $display("FAIL gap_hold[%0d]: got %0d expected 10", i, out_sum); else n_pass++;
    end
    drive(1'b1, 20, 1'b0);
    n_total++; if (out_valid !== 1'b1) $display("FAIL gap_valid1: got %0b expected 1", out_valid); else n_pass++;
    n_total++; if (out_sum !== SUM_W'(30)) $display("FAIL gap_sum1: got %0d expected 30", out_sum); else n_pass++;
    n_total++; if (out_avg !== DATA_W'(e30)) $display("FAIL gap_avg1: got %0d expected %0d", out_avg, e30); else n_pass++;
  endtask

  task automatic test_clr();
    drive(1'b1, 50, 1'b1);
    n_total++; if (out_valid !== 1'b0) $display("FAIL clr_valid: got %0b expected 0", out_valid); else n_pass++;
    n_total++; if (out_sum !== '0) $display("FAIL clr_sum: got %0d expected 0", out_sum); else n_pass++;
    n_total++; if (out_avg !== '0) $display("FAIL clr_avg: got %0d expected 0", out_avg); else n_pass++;
    n_total++; if (out_full !== 1'b0) $display("FAIL clr_full: got %0b expected 0", out_full); else n_pass++;
    drive(1'b1, 8, 1'b0);
    n_total++; if (out_sum !== SUM_W'(8)) $display("FAIL post_clr_sum: got %0d expected 8", out_sum); else n_pass++;
    n_total++; if (out_avg !== DATA_W'(2)) $display("FAIL post_clr_avg: got %0d expected 2", out_avg); else n_pass++;
  endtask

  task automatic test_async_reset();
    drive(1'b1, 60, 1'b0);
    drive(1'b1, 61, 1'b0);
    drive(1'b1, 62, 1'b0);
    @(negedge system1000);
    #2;
    in_valid = 1'b0;
    system1000_rstn = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL arst_valid: got %0b expected 0", out_valid); else n_pass++;
    n_total++; if (out_sum !== '0) $display("FAIL arst_sum: got %0d expected 0", out_sum); else n_pass++;
    n_total++; if (out_avg !== '0) $display("FAIL arst_avg: got %0d expected 0", out_avg); else n_pass++;
    n_total++; if (out_full !== 1'b0) $display("FAIL arst_full: got %0b expected 0", out_full); else n_pass++;
    @(posedge system1000);
    @(negedge system1000);
    system1000_rstn = 1'b1;
    test_warmup("rerun");
  endtask

  initial begin
    test_reset();
    test_warmup("warmup");
    test_evict();
    test_extremes();
    test_rounding();
    test_gapped();
    test_clr();
    test_async_reset();
    drive(1'b0, 0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/moving_average_n.md
Name: moving_average_n

Overview:
- Parametrised successor to the fixed 16-tap, 8-bit moving-average block.
- Computes a running window sum and its mean over the last N = 2**LOG2N accepted samples.
- Sample width is generic; the accumulator is widened so it cannot wrap.
- Adds valid-qualified input, warm-up tracking, synchronous clear and a registered output; sits in the DSP datapath between sample source and downstream filters.

Parameters:
- DATA_W, 8, signed sample width in bits (>=2)
- LOG2N, 4, log2 of window depth; N = 2**LOG2N (1..8)
- SUM_W, DATA_W+LOG2N, accumulator width (derived, not overridable)

Ports:
- system1000  in  1  clock
- system1000_rstn  in  1  asynchronous reset, active low
- clr  in  1  synchronous clear of window state; overrides in_valid
- in_valid  in  1  in_data is a sample this cycle
- in_data  in  DATA_W  signed sample
- out_valid  out  1  out_avg/out_sum updated this cycle
- out_avg  out  DATA_W  signed window mean
- out_sum  out  SUM_W  signed window sum
- out_full  out  1  window holds N valid samples

Behaviour:
- Interface: one clock, system1000; reset is asynchronous and active-low, system1000_rstn.
- Reset: out_valid=0, out_avg=0, out_sum=0, out_full=0, sum=0, wr_ptr=0, fill=0. Buffer contents are not reset.
- Storage:
  - N-entry circular buffer of DATA_W, wr_ptr of LOG2N bits, fill counter 0..N (saturating).
  - wr_ptr wraps N-1 -> 0.
- Accept (in_valid=1, clr=0):
  - oldest = buf[wr_ptr] when fill==N, else 0; the warm-up mask replaces any buffer clearing.
  - sum_n = sum + sext(in_data) - sext(oldest), computed at SUM_W; no overflow is possible by construction.
  - Write buf[wr_ptr] = in_data; wr_ptr++; fill++ if fill<N.
  - Register sum=sum_n, out_sum=sum_n, out_avg=sum_n>>>LOG2N (arithmetic shift, floor toward -inf), out_valid=1.
- Latency: exactly 1 cycle from accept to out_valid. Throughput: 1 sample/cycle.
- No accept: out_valid=0; out_avg/out_sum/sum hold.
- out_full: registered; equals (fill==N) after update. Goes high in the same cycle as the out_valid for the N-th sample.
- During warm-up (fill<N), out_avg is still sum/N, i.e. the average with zero padding (same as the fixed-depth block from reset).
- clr=1 (with or without in_valid):
  - Next cycle sum=0, fill=0, wr_ptr=0, out_full=0, out_valid=0, out_sum=0, out_avg=0.
  - The concurrent sample is dropped.
- Async reset mid-stream: all registers return to reset values immediately; the next accepted sample behaves as the first.
- LOG2N=0 is not allowed (elaboration-time assertion); N=1 is LOG2N... not supported in the minimum case; the minimum is N=2.

Optional Feature:
- MOVING_AVERAGE_ROUND_EN defined: out_avg = (sum_n + 2**(LOG2N-1)) >>> LOG2N.
  - Rounds half toward +inf.
  - Computed at SUM_W+1 bits, then truncated to DATA_W; the result always fits.
- Undefined: plain floor shift as above.
- out_sum is identical in both builds.

Decomposition:
- Package moving_average_pkg:
  - function sum_width(data_w, log2n).
  - Rounding-offset constant function.
  - Parameter-legality checks (DATA_W>=2, 1<=LOG2N<=8).
- Sub-module mavg_window_buf:
  - Circular buffer + wr_ptr + fill counter.
  - Outputs oldest (masked to 0 until full) and full.
- Top holds accumulator, divide/round and output registers.

Test Plan (DATA_W=8, LOG2N=2, N=4):
- Reset, then samples 4,8,12,16 on consecutive cycles -> out_sum 4,12,24,40; out_avg 1,3,6,10; out_full rises with the 4th result.
- Continue with 20 -> out_sum 56 (40+20-4), out_avg 14; out_valid exactly one cycle after each in_valid.
- Steady 127 x6 -> out_sum 508, out_avg 127; then -128 x4 -> out_sum -512, out_avg -128 (no wrap).
- Samples 1,0,0,0 -> sum 1, out_avg 0 (floor); with MOVING_AVERAGE_ROUND_EN: 2,0,0,0 -> out_avg 1; -1,0,0,0 -> floor -1, rounded 0.
- Gapped in_valid (1-0-0-1 pattern) with values 10,20 -> outputs hold between accepts; out_sum 10 then 30.
- clr asserted together with in_valid=1, in_data=50 mid-window -> next cycle out_sum=0, out_full=0, out_valid=0; next sample 8 -> out_sum 8, out_avg 2.
- Async reset pulsed mid-stream -> outputs 0 immediately; the following sequence reproduces the first scenario.
